ingress_port_arbiter: RTL and testbench
=======================================

INGRESS_PORT_ARBITER -- requirements
Module: ingress_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of upstream ingress ports; the design SHALL support exactly 4.
REQ-002 Parameter LEN_W, default 11, width of the frame-length field in a pointer word.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 port_en  input  4  per-port enable; a disabled port is never newly granted.
REQ-006 up_ptr_empty  input  4  per-port pointer FIFO empty flags.
REQ-007 up_ptr_dout  input  64  per-port pointer words, port i at [16i+15:16i], bits [10:0] = frame length in bytes.
REQ-008 up_ptr_rd  output  4  per-port pointer FIFO read strobes.
REQ-009 up_data_dout  input  32  per-port byte FIFO data, port i at [8i+7:8i], valid the cycle after its read.
REQ-010 up_data_rd  output  4  per-port byte FIFO read strobes.
REQ-011 ptr_sfifo_empty  output  1  merged pointer-FIFO empty flag to the frame processor.
REQ-012 ptr_sfifo_dout  output  16  merged pointer word to the frame processor.
REQ-013 ptr_sfifo_rd  input  1  pointer read strobe from the frame processor.
REQ-014 sfifo_rd  input  1  byte read strobe from the frame processor.
REQ-015 sfifo_dout  output  8  merged byte data to the frame processor.
REQ-016 grant  output  4  one-hot registered grant, 0 when no port owns the datapath.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, OFFER, LEN, XFER, DRAIN, one-hot encoded.
REQ-019 IDLE: first port i scanning from rr_ptr upward modulo 4 with !up_ptr_empty[i] && port_en[i] SHALL be loaded into grant and state SHALL become OFFER next cycle; if none, stay IDLE.
REQ-020 OFFER: ptr_sfifo_empty SHALL be 0; on ptr_sfifo_rd=1 go to LEN, else stay.
REQ-021 In all states other than OFFER, ptr_sfifo_empty SHALL be 1.
REQ-022 up_ptr_rd SHALL equal grant gated by (state==OFFER && ptr_sfifo_rd), combinational, zero latency.
REQ-023 ptr_sfifo_dout SHALL be up_ptr_dout of the granted port (combinational mux), 0 when grant==0.
REQ-024 LEN: len_reg (LEN_W bits) SHALL capture up_ptr_dout[granted][10:0]; byte_cnt SHALL clear to 0; next state XFER, or DRAIN if captured length is 0.
REQ-025 XFER: up_data_rd SHALL equal grant gated by sfifo_rd (combinational); byte_cnt SHALL increment per sfifo_rd; when the increment makes byte_cnt==len_reg, next state DRAIN.
REQ-026 sfifo_rd outside XFER SHALL produce no up_data_rd and SHALL not change byte_cnt.
REQ-027 sfifo_dout SHALL be up_data_dout of the granted port, held through DRAIN so the last byte (returned one cycle after its read) is delivered; 0 when grant==0.
REQ-028 DRAIN: one cycle; then grant SHALL clear to 0, rr_ptr SHALL become (granted index + 1) mod 4, state IDLE.
REQ-029 Grant SHALL never change between OFFER and DRAIN inclusive, regardless of port_en or other ports' empty flags.
REQ-030 Minimum inter-frame gap: a new OFFER SHALL start no earlier than 2 cycles after DRAIN (DRAIN, IDLE, OFFER).
REQ-031 rr_ptr SHALL be 2 bits and wrap 3 -> 0.
REQ-032 Deasserting port_en[g] mid-frame SHALL not abort the frame; it only blocks future grants.
REQ-033 Granted port's up_ptr_empty rising in OFFER is an upstream protocol error; the block SHALL stay in OFFER and continue presenting ptr_sfifo_empty=0.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, grant 0, rr_ptr 0, len_reg 0, byte_cnt 0, busy 0, ptr_sfifo_empty 1, up_ptr_rd 0, up_data_rd 0, ptr_sfifo_dout 0, sfifo_dout 0, including mid-frame.
REQ-035 After rst release the first arbitration SHALL start from port 0.

Verification
REQ-036 Single port: port 2 holds ptr 0x0040 (len 64); frame processor reads ptr then 64 bytes -> grant=0100 from OFFER to DRAIN, up_data_rd[2] pulses 64 times, DRAIN after 64th read, rr_ptr=3.
REQ-037 Round robin: all 4 ports non-empty continuously, len 60 each -> grant order 0,1,2,3,0 with no port repeated before others served.
REQ-038 port_en=1011 with all non-empty -> port 2 never granted; clearing port_en[1] during port 1's XFER still completes its 60 bytes.
REQ-039 Zero length: ptr word 0x0000 on port 0 -> LEN goes directly to DRAIN, zero up_data_rd pulses, grant clears after DRAIN.
REQ-040 Reset mid-XFER after 20 of 64 bytes -> all outputs to reset values same cycle; after release port 0 wins first arbitration.
REQ-041 Stray strobes: sfifo_rd and ptr_sfifo_rd pulsed in IDLE -> no up_ptr_rd or up_data_rd, byte_cnt unchanged.

Source files
------------

// File: rtl/ingress_port_arbiter.sv
// Round-robin merge of four ingress pointer/byte FIFO pairs into one frame-processor stream.
// A port owns the datapath for a whole frame: pointer offer, length capture, byte transfer, drain.
module ingress_port_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned LEN_W     = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    port_en,
  input  logic [NUM_PORTS-1:0]    up_ptr_empty,
  input  logic [16*NUM_PORTS-1:0] up_ptr_dout,
  output logic [NUM_PORTS-1:0]    up_ptr_rd,
  input  logic [8*NUM_PORTS-1:0]  up_data_dout,
  output logic [NUM_PORTS-1:0]    up_data_rd,
  output logic                    ptr_sfifo_empty,
  output logic [15:0]             ptr_sfifo_dout,
  input  logic                    ptr_sfifo_rd,
  input  logic                    sfifo_rd,
  output logic [7:0]              sfifo_dout,
  output logic [NUM_PORTS-1:0]    grant,
  output logic                    busy
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] OFFER = 5'b00010;
  localparam logic [4:0] LEN   = 5'b00100;
  localparam logic [4:0] XFER  = 5'b01000;
  localparam logic [4:0] DRAIN = 5'b10000;

  logic [4:0]           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] req;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     grant_idx;
  logic [15:0]          ptr_mux;
  logic [7:0]           byte_mux;
  logic [LEN_W-1:0]     cap_len;

  // First requesting port at or above rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    req        = port_en & ~up_ptr_empty;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_W'((32'(rr_q) + k) % NUM_PORTS);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Grant is one-hot, so OR-ing the selected lanes forms the mux; all zero when idle.
  always_comb begin
    grant_idx = '0;
    ptr_mux   = '0;
    byte_mux  = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (grant_q[i]) begin
        grant_idx = IDX_W'(i);
        ptr_mux   = ptr_mux | up_ptr_dout[16*i +: 16];
        byte_mux  = byte_mux | up_data_dout[8*i +: 8];
      end
    end
  end

  assign cap_len = ptr_mux[LEN_W-1:0];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = OFFER;
        end
      end
      OFFER: begin
        // Granted port going empty here is an upstream fault; keep offering regardless.
        if (ptr_sfifo_rd) begin
          state_d = LEN;
        end
      end
      LEN: begin
        len_d   = cap_len;
        cnt_d   = '0;
        state_d = (cap_len == '0) ? DRAIN : XFER;
      end
      XFER: begin
        if (sfifo_rd) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        grant_d = '0;
        rr_d    = grant_idx + 1'b1;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs derive only from registered state so reset clears them without a clock.
  always_comb begin
    grant           = grant_q;
    busy            = (state_q != IDLE);
    ptr_sfifo_empty = (state_q != OFFER);
    ptr_sfifo_dout  = ptr_mux;
    sfifo_dout      = byte_mux;
    up_ptr_rd       = grant_q & {NUM_PORTS{(state_q == OFFER) && ptr_sfifo_rd}};
    up_data_rd      = grant_q & {NUM_PORTS{(state_q == XFER) && sfifo_rd}};
  end

endmodule

// File: tb/tb_ingress_port_arbiter.sv
// Self-checking bench: table of frames plus hand sequences for reset, stray strobes and
// protocol-error corner cases; merged bytes checked through a scoreboard queue.
module tb_ingress_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  port_en;
  logic [3:0]  up_ptr_empty;
  logic [63:0] up_ptr_dout;
  logic [3:0]  up_ptr_rd;
  logic [31:0] up_data_dout;
  logic [3:0]  up_data_rd;
  logic        ptr_sfifo_empty;
  logic [15:0] ptr_sfifo_dout;
  logic        ptr_sfifo_rd;
  logic        sfifo_rd;
  logic [7:0]  sfifo_dout;
  logic [3:0]  grant;
  logic        busy;

  ingress_port_arbiter #(.NUM_PORTS(4), .LEN_W(11)) dut (
    .clk             (clk),
    .rst             (rst),
    .port_en         (port_en),
    .up_ptr_empty    (up_ptr_empty),
    .up_ptr_dout     (up_ptr_dout),
    .up_ptr_rd       (up_ptr_rd),
    .up_data_dout    (up_data_dout),
    .up_data_rd      (up_data_rd),
    .ptr_sfifo_empty (ptr_sfifo_empty),
    .ptr_sfifo_dout  (ptr_sfifo_dout),
    .ptr_sfifo_rd    (ptr_sfifo_rd),
    .sfifo_rd        (sfifo_rd),
    .sfifo_dout      (sfifo_dout),
    .grant           (grant),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       do_rst;
    logic [3:0] en;
    logic [3:0] en_mid;
    logic [3:0] empty;
    int       port;
    int       len;
  } vec_t;

  vec_t vecs[12];

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] data_q[4] = '{default: 8'h00};
  int seq_up[4]  = '{default: 0};
  int seq_exp[4] = '{default: 0};

  // Upstream byte FIFOs: each read returns {port, sequence} one cycle later.
  assign up_data_dout = {data_q[3], data_q[2], data_q[1], data_q[0]};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (up_data_rd[i]) begin
        data_q[i] <= {2'(i), 6'(seq_up[i])};
        seq_up[i] <= seq_up[i] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input int len);
    for (int i = 0; i < 4; i++) begin
      up_ptr_dout[16*i +: 16] = {2'(i), 3'b000, 11'(len)};
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sfifo_rd     = 1'b0;
    ptr_sfifo_rd = 1'b0;
    port_en      = 4'h0;
    up_ptr_empty = 4'hF;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ptr_empty", 32'(ptr_sfifo_empty), 32'h1);
  endtask

  task automatic run_frame(input vec_t v);
    int p;
    logic [3:0] oh;
    int pulses;
    int cnt;
    int budget;
    bit got;
    bit rd;
    p  = v.port;
    oh = 4'b0001 << p;
    if (v.do_rst) do_reset();
    port_en      = v.en;
    up_ptr_empty = v.empty;
    set_words(v.len);
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      tick();
      if (grant != 4'h0) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL grant_timeout: got 0 expected %0h at %0t", oh, $time);
      return;
    end
    #1;
    check("offer_grant", 32'(grant), 32'(oh));
    check("offer_busy", 32'(busy), 32'h1);
    check("offer_ptr_empty", 32'(ptr_sfifo_empty), 32'h0);
    check("offer_ptr_dout", 32'(ptr_sfifo_dout), 32'({2'(p), 3'b000, 11'(v.len)}));
    check("offer_no_rd", 32'(up_ptr_rd), 32'h0);
    tick();
    check("offer_hold", 32'(ptr_sfifo_empty), 32'h0);
    ptr_sfifo_rd = 1'b1;
    #1;
    check("up_ptr_rd", 32'(up_ptr_rd), 32'(oh));
    tick();
    ptr_sfifo_rd = 1'b0;
    port_en      = v.en_mid;
    up_ptr_empty = ~v.empty;
    #1;
    check("len_ptr_empty", 32'(ptr_sfifo_empty), 32'h1);
    check("len_grant", 32'(grant), 32'(oh));
    tick();
    pulses = 0;
    cnt    = 0;
    budget = 0;
    while (cnt < v.len && budget < 8 * v.len + 16) begin
      rd       = ($urandom_range(0, 3) != 0);
      sfifo_rd = rd;
      #1;
      check("up_data_rd", 32'(up_data_rd), rd ? 32'(oh) : 32'h0);
      if (up_data_rd[p]) pulses++;
      if (rd) begin
        exp_q.push_back({2'(p), 6'(seq_exp[p])});
        seq_exp[p]++;
        cnt++;
      end
      tick();
      sfifo_rd = 1'b0;
      #1;
      if (rd) check("sfifo_dout", 32'(sfifo_dout), 32'(exp_q.pop_front()));
      budget++;
    end
    check("byte_pulses", 32'(pulses), 32'(v.len));
    check("drain_grant", 32'(grant), 32'(oh));
    check("drain_busy", 32'(busy), 32'h1);
    tick();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_sfifo_dout", 32'(sfifo_dout), 32'h0);
    check("idle_ptr_empty", 32'(ptr_sfifo_empty), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t extra;
    rst          = 1'b1;
    port_en      = 4'h0;
    up_ptr_empty = 4'hF;
    up_ptr_dout  = '0;
    ptr_sfifo_rd = 1'b0;
    sfifo_rd     = 1'b0;

    vecs[0]  = '{1'b1, 4'hF, 4'hF, 4'b1011, 2, 64};
    vecs[1]  = '{1'b1, 4'hF, 4'hF, 4'b0000, 0, 60};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 4'b0000, 1, 60};
    vecs[3]  = '{1'b0, 4'hF, 4'hF, 4'b0000, 2, 60};
    vecs[4]  = '{1'b0, 4'hF, 4'hF, 4'b0000, 3, 60};
    vecs[5]  = '{1'b0, 4'hF, 4'hF, 4'b0000, 0, 60};
    vecs[6]  = '{1'b0, 4'b1011, 4'b1001, 4'b0000, 1, 60};
    vecs[7]  = '{1'b0, 4'b1001, 4'b1001, 4'b0000, 3, 60};
    vecs[8]  = '{1'b0, 4'b1011, 4'b1011, 4'b0000, 0, 0};
    vecs[9]  = '{1'b0, 4'b1011, 4'b1011, 4'b0000, 1, 5};
    vecs[10] = '{1'b0, 4'b1011, 4'b1011, 4'b0000, 3, 1};
    vecs[11] = '{1'b0, 4'b1011, 4'b1011, 4'b0000, 0, 3};

    for (int r = 0; r < 12; r++) run_frame(vecs[r]);

    // Stray strobes while idle, then a frame proves the byte counter was untouched.
    do_reset();
    port_en      = 4'hF;
    sfifo_rd     = 1'b1;
    ptr_sfifo_rd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stray_ptr_rd", 32'(up_ptr_rd), 32'h0);
      check("stray_data_rd", 32'(up_data_rd), 32'h0);
      check("stray_ptr_empty", 32'(ptr_sfifo_empty), 32'h1);
      tick();
    end
    sfifo_rd     = 1'b0;
    ptr_sfifo_rd = 1'b0;
    extra = '{1'b0, 4'hF, 4'hF, 4'b1110, 0, 4};
    run_frame(extra);

    // Granted port goes empty during OFFER while others request: grant and offer persist.
    do_reset();
    port_en      = 4'hF;
    up_ptr_empty = 4'b1110;
    set_words(9);
    tick();
    #1;
    check("perr_grant", 32'(grant), 32'h1);
    up_ptr_empty = 4'b0001;
    port_en      = 4'b0010;
    tick();
    tick();
    check("perr_grant_hold", 32'(grant), 32'h1);
    check("perr_ptr_empty", 32'(ptr_sfifo_empty), 32'h0);
    check("perr_busy", 32'(busy), 32'h1);

    // Reset after 20 of 64 bytes: outputs clear at once, port 0 wins afterwards.
    do_reset();
    port_en      = 4'hF;
    up_ptr_empty = 4'b1011;
    set_words(64);
    tick();
    #1;
    check("mid_grant", 32'(grant), 32'h4);
    ptr_sfifo_rd = 1'b1;
    tick();
    ptr_sfifo_rd = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      sfifo_rd = 1'b1;
      #1;
      check("mid_data_rd", 32'(up_data_rd), 32'h4);
      exp_q.push_back({2'd2, 6'(seq_exp[2])});
      seq_exp[2]++;
      tick();
      #1;
      check("mid_sfifo_dout", 32'(sfifo_dout), 32'(exp_q.pop_front()));
    end
    ptr_sfifo_rd = 1'b1;
    rst          = 1'b1;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_ptr_empty", 32'(ptr_sfifo_empty), 32'h1);
    check("arst_ptr_rd", 32'(up_ptr_rd), 32'h0);
    check("arst_data_rd", 32'(up_data_rd), 32'h0);
    check("arst_ptr_dout", 32'(ptr_sfifo_dout), 32'h0);
    check("arst_sfifo_dout", 32'(sfifo_dout), 32'h0);
    tick();
    rst          = 1'b0;
    sfifo_rd     = 1'b0;
    ptr_sfifo_rd = 1'b0;
    up_ptr_empty = 4'b0000;
    tick();
    #1;
    check("post_rst_grant", 32'(grant), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
